// File: rtl/irq_flag_responder_if.sv
// MMIO bus between the core and the IF register responder.
// The core drives address, strobes and write data; the responder returns read data and its drive enable.
interface irq_flag_responder_if;
    logic [15:0] A;
    logic [7:0]  D_IN;
    logic [7:0]  D_OUT;
    logic        D_OE;
    logic        RD;
    logic        WR;
    logic        MMIO_REQ;

    modport master (output A, D_IN, RD, WR, MMIO_REQ, input D_OUT, D_OE);
    modport slave  (input A, D_IN, RD, WR, MMIO_REQ, output D_OUT, D_OE);
endinterface

// File: rtl/irq_flag_responder.sv
// IF register (0xFF0F): latches peripheral request edges and presents them to the core on CPU_IRQ_TRIG.
// Flags update one CLK edge after the event; reads are combinational; there is no backpressure and every strobe completes.
module irq_flag_responder #(
    parameter int          NSRC      = 5,
    parameter logic [15:0] IF_ADDR   = 16'hFF0F,
    parameter logic        UNUSED_RD = 1'b1
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic [NSRC-1:0]  SRC_REQ,
    input  logic [7:0]       CPU_IRQ_ACK,
    output logic [7:0]       CPU_IRQ_TRIG,
    irq_flag_responder_if.slave bus
);
    logic [NSRC-1:0] if_q;
    logic [NSRC-1:0] src_q;
    logic            wr_q;

    logic            hit;
    logic            wstb;
    logic [NSRC-1:0] set_edge;
    logic [NSRC-1:0] if_d;
    logic [7:0]      rd_val;

    // Only the low NSRC bits of ACK and write data are meaningful.
    logic unused;
    assign unused = &{1'b0, CPU_IRQ_ACK, bus.D_IN};

    assign hit      = bus.MMIO_REQ & (bus.A == IF_ADDR);
    assign wstb     = bus.WR & hit & ~wr_q;
    assign set_edge = SRC_REQ & ~src_q;

    // A fresh source edge outranks both a write of 0 and an ACK.
    always_comb begin
        if_d = wstb ? bus.D_IN[NSRC-1:0] : if_q;
        if_d = if_d & ~CPU_IRQ_ACK[NSRC-1:0];
        if_d = if_d | set_edge;
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            if_q  <= '0;
            src_q <= '0;
            wr_q  <= 1'b0;
        end else begin
            if_q  <= if_d;
            src_q <= SRC_REQ;
            wr_q  <= bus.WR & hit;
        end
    end

    always_comb begin
        CPU_IRQ_TRIG             = 8'h00;
        CPU_IRQ_TRIG[NSRC-1:0]   = if_q;
        rd_val                   = {8{UNUSED_RD}};
        rd_val[NSRC-1:0]         = if_q;
    end

    // Drive enable is gated by reset so the bus stays quiet while held.
    assign bus.D_OE  = bus.RD & hit & ~bus.WR & nRESET;
    assign bus.D_OUT = bus.D_OE ? rd_val : 8'hFF;
endmodule

// File: tb/tb_irq_flag_responder.sv
// Randomized and directed bench for irq_flag_responder against a per-bit behavioural model.
module tb_irq_flag_responder;
    logic       CLK = 1'b0;
    logic       nRESET = 1'b0;
    logic [4:0] SRC_REQ = '0;
    logic [7:0] CPU_IRQ_ACK = '0;
    logic [7:0] CPU_IRQ_TRIG;

    irq_flag_responder_if bus ();

    irq_flag_responder #(.NSRC(5), .IF_ADDR(16'hFF0F), .UNUSED_RD(1'b1)) dut (
        .CLK(CLK), .nRESET(nRESET), .SRC_REQ(SRC_REQ), .CPU_IRQ_ACK(CPU_IRQ_ACK),
        .CPU_IRQ_TRIG(CPU_IRQ_TRIG), .bus(bus.slave)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model state: flag bits, previous request levels, previous write-hit level.
    bit [4:0] m_if;
    bit [4:0] m_src;
    bit       m_wrq;

    function automatic bit cur_hit();
        return bus.MMIO_REQ && (bus.A == 16'hFF0F);
    endfunction

    function automatic bit exp_oe();
        return nRESET && bus.RD && !bus.WR && cur_hit();
    endfunction

    function automatic logic [7:0] exp_dout();
        return exp_oe() ? {3'b111, m_if} : 8'hFF;
    endfunction

    task automatic model_reset();
        m_if = '0; m_src = '0; m_wrq = 1'b0;
    endtask

    task automatic tick();
        bit wstb;
        bit v;
        @(posedge CLK);
        if (!nRESET) begin
            model_reset();
        end else begin
            wstb = bus.WR && cur_hit() && !m_wrq;
            for (int i = 0; i < 5; i++) begin
                v = wstb ? bus.D_IN[i] : m_if[i];
                if (CPU_IRQ_ACK[i]) v = 1'b0;
                if (SRC_REQ[i] && !m_src[i]) v = 1'b1;
                m_if[i] = v;
            end
            m_src = SRC_REQ;
            m_wrq = bus.WR && cur_hit();
        end
        #1;
    endtask

    task automatic bus_idle();
        bus.A = 16'h0000; bus.D_IN = 8'h00; bus.RD = 1'b0; bus.WR = 1'b0; bus.MMIO_REQ = 1'b0;
    endtask

    task automatic write_if(input logic [7:0] val);
        bus.A = 16'hFF0F; bus.MMIO_REQ = 1'b1; bus.WR = 1'b1; bus.D_IN = val;
        tick();
        bus_idle();
        tick();
    endtask

    task automatic test_reset();
        bus_idle();
        model_reset();
        nRESET = 1'b0;
        bus.A = 16'hFF0F; bus.MMIO_REQ = 1'b1; bus.RD = 1'b1;
        repeat (2) tick();
        checks++;
        if (CPU_IRQ_TRIG !== 8'h00) begin errors++; $display("FAIL reset_trig got=%h exp=00", CPU_IRQ_TRIG); end
        checks++;
        if (bus.D_OE !== 1'b0) begin errors++; $display("FAIL reset_oe got=%b exp=0", bus.D_OE); end
        checks++;
        if (bus.D_OUT !== 8'hFF) begin errors++; $display("FAIL reset_dout got=%h exp=FF", bus.D_OUT); end
        nRESET = 1'b1;
        #1;
        checks++;
        if (bus.D_OUT !== 8'hE0 || bus.D_OE !== 1'b1) begin
            errors++; $display("FAIL reset_read got=%h/%b exp=E0/1", bus.D_OUT, bus.D_OE);
        end
        bus_idle();
        tick();
    endtask

    task automatic test_src_pulse();
        SRC_REQ = 5'b00100;
        tick();
        SRC_REQ = '0;
        checks++;
        if (CPU_IRQ_TRIG !== 8'h04 || {3'b000, m_if} !== CPU_IRQ_TRIG) begin
            errors++; $display("FAIL pulse_trig got=%h exp=04", CPU_IRQ_TRIG);
        end
        bus.A = 16'hFF0F; bus.MMIO_REQ = 1'b1; bus.RD = 1'b1;
        #1;
        checks++;
        if (bus.D_OUT !== 8'hE4 || bus.D_OE !== 1'b1) begin
            errors++; $display("FAIL pulse_read got=%h/%b exp=E4/1", bus.D_OUT, bus.D_OE);
        end
        tick();
        bus_idle();
        write_if(8'h00);
    endtask

    task automatic test_hold_ack();
        SRC_REQ = 5'b00001;
        repeat (10) tick();
        checks++;
        if (CPU_IRQ_TRIG !== 8'h01) begin errors++; $display("FAIL hold_set got=%h exp=01", CPU_IRQ_TRIG); end
        CPU_IRQ_ACK = 8'h01;
        tick();
        CPU_IRQ_ACK = 8'h00;
        checks++;
        if (CPU_IRQ_TRIG !== 8'h00) begin errors++; $display("FAIL hold_ack got=%h exp=00", CPU_IRQ_TRIG); end
        repeat (3) tick();
        checks++;
        if (CPU_IRQ_TRIG !== 8'h00) begin errors++; $display("FAIL hold_stay got=%h exp=00", CPU_IRQ_TRIG); end
        SRC_REQ = '0;
        tick();
    endtask

    task automatic test_write_vs_edge();
        write_if(8'h1F);
        checks++;
        if (CPU_IRQ_TRIG !== 8'h1F) begin errors++; $display("FAIL sw_set got=%h exp=1F", CPU_IRQ_TRIG); end
        bus.A = 16'hFF0F; bus.MMIO_REQ = 1'b1; bus.WR = 1'b1; bus.D_IN = 8'h00;
        SRC_REQ = 5'b01000;
        tick();
        bus_idle();
        SRC_REQ = '0;
        checks++;
        if (CPU_IRQ_TRIG !== 8'h08) begin errors++; $display("FAIL wr_edge got=%h exp=08", CPU_IRQ_TRIG); end
        tick();
        write_if(8'h00);
    endtask

    task automatic test_back_to_back();
        bus.A = 16'hFF0F; bus.MMIO_REQ = 1'b1; bus.WR = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            bus.D_IN = 8'(k);
            tick();
        end
        bus_idle();
        tick();
        checks++;
        if (CPU_IRQ_TRIG !== 8'h01) begin errors++; $display("FAIL wr_hold got=%h exp=01", CPU_IRQ_TRIG); end
        write_if(8'h00);
    endtask

    task automatic test_miss();
        bit oe_seen = 1'b0;
        bus.A = 16'hFF0E; bus.MMIO_REQ = 1'b1; bus.WR = 1'b1; bus.D_IN = 8'h10;
        #1 oe_seen |= bus.D_OE;
        tick();
        bus.WR = 1'b0; bus.RD = 1'b1;
        #1 oe_seen |= bus.D_OE;
        tick();
        bus.A = 16'hFF0F; bus.MMIO_REQ = 1'b0; bus.RD = 1'b0; bus.WR = 1'b1;
        #1 oe_seen |= bus.D_OE;
        tick();
        bus.WR = 1'b0; bus.RD = 1'b1;
        #1 oe_seen |= bus.D_OE;
        tick();
        bus_idle();
        checks++;
        if (CPU_IRQ_TRIG !== 8'h00) begin errors++; $display("FAIL miss_if got=%h exp=00", CPU_IRQ_TRIG); end
        checks++;
        if (oe_seen !== 1'b0) begin errors++; $display("FAIL miss_oe got=%b exp=0", oe_seen); end
    endtask

    task automatic test_ack_edge_reset();
        write_if(8'h06);
        CPU_IRQ_ACK = 8'h04; SRC_REQ = 5'b00100;
        tick();
        CPU_IRQ_ACK = 8'h00;
        checks++;
        if (CPU_IRQ_TRIG !== 8'h06) begin errors++; $display("FAIL ack_edge got=%h exp=06", CPU_IRQ_TRIG); end
        #2;
        nRESET = 1'b0;
        model_reset();
        bus.A = 16'hFF0F; bus.MMIO_REQ = 1'b1; bus.RD = 1'b1;
        #1;
        checks++;
        if (CPU_IRQ_TRIG !== 8'h00) begin errors++; $display("FAIL async_rst got=%h exp=00", CPU_IRQ_TRIG); end
        checks++;
        if (bus.D_OE !== 1'b0 || bus.D_OUT !== 8'hFF) begin
            errors++; $display("FAIL async_rst_bus got=%h/%b exp=FF/0", bus.D_OUT, bus.D_OE);
        end
        SRC_REQ = '0;
        bus.RD = 1'b0; bus.WR = 1'b1; bus.D_IN = 8'h02;
        tick();
        nRESET = 1'b1;
        tick();
        bus_idle();
        tick();
        checks++;
        if (CPU_IRQ_TRIG !== 8'h02) begin errors++; $display("FAIL rst_wr_held got=%h exp=02", CPU_IRQ_TRIG); end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 400; n++) begin
            bus.A        = ($urandom_range(0, 3) != 0) ? 16'hFF0F : 16'(16'hFF00 + $urandom_range(0, 31));
            bus.MMIO_REQ = ($urandom_range(0, 4) != 0);
            bus.RD       = $urandom_range(0, 1);
            bus.WR       = ($urandom_range(0, 3) == 0);
            bus.D_IN     = 8'($urandom);
            for (int i = 0; i < 5; i++)
                if ($urandom_range(0, 3) == 0) SRC_REQ[i] = ~SRC_REQ[i];
            CPU_IRQ_ACK  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            #1;
            checks++;
            if (CPU_IRQ_TRIG !== {3'b000, m_if} || bus.D_OE !== exp_oe() || bus.D_OUT !== exp_dout()) begin
                errors++;
                if (bad < 5)
                    $display("FAIL rand_cycle%0d got trig=%h oe=%b dout=%h exp trig=%h oe=%b dout=%h",
                             n, CPU_IRQ_TRIG, bus.D_OE, bus.D_OUT, {3'b000, m_if}, exp_oe(), exp_dout());
                bad++;
            end
            tick();
        end
        bus_idle();
        SRC_REQ = '0; CPU_IRQ_ACK = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_src_pulse();
        test_hold_ack();
        test_write_vs_edge();
        test_back_to_back();
        test_miss();
        test_ack_edge_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/irq_flag_responder.md
Name: irq_flag_responder

Overview:
- MMIO-side responder for the SM83 core's interrupt interface.
- Latches edge-triggered peripheral interrupt requests into the IF register at 0xFF0F.
- Presents the pending flags to the core on CPU_IRQ_TRIG and clears them on CPU_IRQ_ACK.
- Serves core reads and writes of IF over the MMIO bus (RD/WR/A/D with MMIO_REQ qualification).

Parameters:
- NSRC, 5, number of implemented interrupt sources (1..8); IF bits at or above NSRC read as 1 and are never set.
- IF_ADDR, 16'hFF0F, bus address of the IF register.
- UNUSED_RD, 1'b1, read value of unimplemented IF bits.

Ports:
- CLK  input  1  single system clock; all state updates on rising edge.
- nRESET  input  1  asynchronous active-low reset.
- SRC_REQ  input  NSRC  raw peripheral request lines; rising edge sets the matching IF bit.
- A  input  16  core address bus.
- D_IN  input  8  core write data.
- D_OUT  output  8  read data for IF.
- D_OE  output  1  read-data drive enable toward the core data bus.
- RD  input  1  core read strobe.
- WR  input  1  core write strobe.
- MMIO_REQ  input  1  high when A is 0xFExx/0xFFxx.
- CPU_IRQ_TRIG  output  8  pending flags to core; bit i = IF[i], bits at or above NSRC = 0.
- CPU_IRQ_ACK  input  8  core acknowledge, level; bit i high clears IF[i].

Behaviour:
- Reset (nRESET low, asynchronous): IF=0, src_q=0, wr_q=0. CPU_IRQ_TRIG=0, D_OE=0, D_OUT=8'hFF (all ones). Remains held while nRESET is low. Release is synchronous to the next CLK edge.
- hit = MMIO_REQ & (A == IF_ADDR).
- Source edge detect:
  - src_q <= SRC_REQ every cycle.
  - set[i] = SRC_REQ[i] & ~src_q[i].
  - A request held high sets IF exactly once. A request that is already high when reset releases does not set IF until it toggles.
- Write detect:
  - wr_q <= WR & hit.
  - wstb = WR & hit & ~wr_q, which is one cycle per strobe regardless of WR length.
  - Write data is the D_IN sampled in the wstb cycle.
- IF next-state per implemented bit i, in priority order:
  1. base = wstb ? D_IN[i] : IF[i].
  2. base &= ~CPU_IRQ_ACK[i].
  3. IF[i] <= base | set[i].
  - A new source edge always wins, so a request coinciding with a write of 0 or with an ACK is never lost.
  - A write of 1 raises the request, giving software-triggered interrupts.
- CPU_IRQ_TRIG is combinational from IF, so there is zero added latency. A source edge in cycle n is visible on TRIG after the edge ending cycle n.
- Read path:
  - D_OE = RD & hit & ~WR, combinational.
  - D_OUT = {UNUSED_RD for bits at or above NSRC, IF[NSRC-1:0]}.
  - The value read is IF before any same-cycle update.
  - D_OUT is forced to 8'hFF (all ones) whenever D_OE = 0, so the bus is never driven with stale data.
- RD and WR high together: the write takes effect and D_OE = 0.
- CPU_IRQ_ACK bits at or above NSRC are ignored.
- A non-matching address, or MMIO_REQ = 0: no state change apart from source and ACK handling.
- Reset mid-write or mid-ACK: the state is lost and the operation does not resume. wr_q=0 after reset, so a WR still held high at release produces a fresh wstb if the address still hits.

Test Plan:
- Reset, then one-cycle pulse on SRC_REQ[2] -> IF=5'b00100 one edge later; CPU_IRQ_TRIG=8'h04; read 0xFF0F -> D_OUT=8'hE4, D_OE=1.
- Hold SRC_REQ[0] high for 10 cycles, then assert CPU_IRQ_ACK[0] for 1 cycle -> IF[0] set once, cleared after ACK, stays 0 while SRC_REQ[0] is still high; TRIG=8'h00.
- IF=5'h1F; write 8'h00 to 0xFF0F in the same cycle as a SRC_REQ[3] rising edge -> IF=5'b01000, TRIG=8'h08.
- WR held 4 cycles at 0xFF0F with D_IN changing 8'h01 -> 8'h02 -> 8'h03 -> 8'h04 -> IF=5'h01 (first-cycle data only).
- Write 8'h10 at 0xFF0E, and again with MMIO_REQ=0 at 0xFF0F -> IF unchanged (0), D_OE never asserted.
- IF=5'h06 with CPU_IRQ_ACK=8'h04 and SRC_REQ[2] rising edge in the same cycle -> IF=5'h06; assert nRESET low mid-cycle -> IF=0 and TRIG=0 immediately, without waiting for a CLK edge.
